muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand, HI, LO and Result width in bits (even, >= 8).
REQ-002 SHALL have parameter ALUOP_W, default 3, giving the ALUOp width.
REQ-003 SHALL have parameter RTYPE_OP, default 3'b111, the ALUOp code that selects R-type decoding.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ALUOp  input  ALUOP_W  operation class from the main control unit.
REQ-007 ALUFunction  input  6  instruction function field.
REQ-008 Valid  input  1  ALUOp, ALUFunction, A and B are meaningful this cycle.
REQ-009 A  input  WIDTH  rs operand (dividend or multiplicand).
REQ-010 B  input  WIDTH  rt operand (divisor or multiplier).
REQ-011 Result  output  WIDTH  MFHI/MFLO read data.
REQ-012 HI  output  WIDTH  HI register.
REQ-013 LO  output  WIDTH  LO register.
REQ-014 Busy  output  1  iterative operation in progress.
REQ-015 Done  output  1  one-cycle pulse when HI/LO take a mult/div result.
REQ-016 Stall  output  1  request to freeze the issuing pipeline.

Function
REQ-017 Decode applies only when ALUOp==RTYPE_OP; function codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011; all other codes SHALL be ignored (no state change).
REQ-018 FSM states SHALL be IDLE, MUL, DIV, FIX, DONE.
REQ-019 IDLE + Valid + mult/div op: capture operand magnitudes and sign flags (unsigned ops: signs = 0), load the iteration counter with WIDTH, go to MUL or DIV; Busy=1 from the next cycle.
REQ-020 MUL: one radix-2 shift-add step per cycle; DIV: one restoring shift-subtract step per cycle; after WIDTH steps go to FIX.
REQ-021 FIX (1 cycle): negate the product when the signs differ; negate the quotient when the signs differ; remainder takes the dividend sign.
REQ-022 DONE (1 cycle): write {HI,LO} = product, or HI=remainder and LO=quotient; Done=1, Busy=0; return to IDLE next cycle.
REQ-023 Latency: accept at edge k -> Done high during cycle k+WIDTH+2; HI/LO are valid from that cycle onward.
REQ-024 Divide by zero (B==0) SHALL run full latency and yield HI=A, LO=all ones; no exception.
REQ-025 Signed most-negative / -1 SHALL yield LO=most-negative, HI=0.
REQ-026 Result SHALL be the combinational HI (MFHI) or LO (MFLO) when Valid and state is IDLE or DONE; otherwise 0. During DONE it SHALL present the newly written value (bypass).
REQ-027 MTHI/MTLO with Valid in IDLE SHALL write A into HI/LO at the clock edge.
REQ-028 Stall = Valid AND (decoded op is any of the eight) AND state is in {MUL, DIV, FIX}.
REQ-029 Valid with an MDU op while Busy SHALL NOT be accepted; there is no queue, and the issuer holds the op under Stall.
REQ-030 A new mult/div presented during DONE SHALL be accepted only on the following IDLE cycle.

Reset
REQ-031 reset SHALL immediately force IDLE, HI=0, LO=0, Busy=0, Done=0, Stall=0, Result=0 and clear the internal datapath, including mid-operation; the aborted operation leaves no trace.
REQ-032 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-033 Package muldiv_pkg SHALL hold the eight function codes, the RTYPE_OP default and the state enum.
REQ-034 The iterative add/sub-shift datapath SHALL be one sub-module, muldiv_iter_core; the FSM, decode, sign fix and HI/LO live in muldiv_unit.

Verification (WIDTH=32)
REQ-035 MULT A=0xFFFFFFFD, B=7 -> Done at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=5, B=0 -> HI=5, LO=0xFFFFFFFF.
REQ-038 DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 MFLO held Valid from cycle 3 of a MULT -> Stall=1 until DONE, then Result=new LO with Stall=0.
REQ-040 reset asserted at cycle 10 of a MULT -> Busy, Done, HI, LO all 0 immediately; a new MULTU 3*4 then gives LO=12, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the multiply/divide unit.
// Function codes match the R-type funct field of the instruction set.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [2:0] RTYPE_OP_DEFAULT = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply and restoring divide.
// p holds {upper, lower}: product after a multiply, {remainder, quotient} after a divide.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   lo_in,
  input  logic [WIDTH-1:0]   d_in,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] p_r;
  logic [WIDTH-1:0]   d_r;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH-1:0]   sub_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic               ge_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [2*WIDTH-1:0] div_next_s;

  // Next-step values for both algorithms; remainder stays below the divisor so the difference fits WIDTH bits.
  always_comb begin
    sum_s      = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, d_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {sum_s, p_r[WIDTH-1:1]};
    shifted_s  = {p_r[2*WIDTH-1:WIDTH], p_r[WIDTH-1]};
    sub_s      = shifted_s[WIDTH-1:0] - d_r;
    ge_s       = (shifted_s >= {1'b0, d_r});
    if (ge_s) begin
      rem_next_s = sub_s;
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
    div_next_s = {rem_next_s, p_r[WIDTH-2:0], ge_s};
  end

  // Operand load and per-cycle iteration register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_r <= '0;
      d_r <= '0;
    end else if (load) begin
      p_r <= {{WIDTH{1'b0}}, lo_in};
      d_r <= d_in;
    end else if (step) begin
      p_r <= div_mode ? div_next_s : mul_next_s;
    end else begin
      p_r <= p_r;
    end
  end

  assign p = p_r;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: decode, control FSM, sign correction and MFHI/MFLO read port.
// Operands are iterated as magnitudes and the sign is restored in the FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int                 WIDTH    = 32,
  parameter int                 ALUOP_W  = 3,
  parameter logic [ALUOP_W-1:0] RTYPE_OP = ALUOP_W'(RTYPE_OP_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [5:0]         ALUFunction,
  input  logic               Valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   Result,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO,
  output logic               Busy,
  output logic               Done,
  output logic               Stall
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               sign_a_r, sign_b_r, div0_r, op_div_r;
  logic [WIDTH-1:0]   hi_r, lo_r, result_s;
  logic               busy_r, done_r;
  logic               is_mul_s, is_div_s, is_signed_s, mthi_s, mtlo_s, mfhi_s, mflo_s, is_mdu_s;
  logic               neg_a_s, neg_b_s, load_s, step_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_s, rem_s, fix_hi_s, fix_lo_s;
  logic [2*WIDTH-1:0] core_p_s, prod_s;

  // Function decode, gated by Valid and the R-type class.
  always_comb begin
    is_mul_s    = 1'b0;
    is_div_s    = 1'b0;
    is_signed_s = 1'b0;
    mthi_s      = 1'b0;
    mtlo_s      = 1'b0;
    mfhi_s      = 1'b0;
    mflo_s      = 1'b0;
    if (Valid && (ALUOp == RTYPE_OP)) begin
      case (ALUFunction)
        FN_MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
        FN_MULTU: is_mul_s = 1'b1;
        FN_DIV:   begin is_div_s = 1'b1; is_signed_s = 1'b1; end
        FN_DIVU:  is_div_s = 1'b1;
        FN_MTHI:  mthi_s = 1'b1;
        FN_MTLO:  mtlo_s = 1'b1;
        FN_MFHI:  mfhi_s = 1'b1;
        FN_MFLO:  mflo_s = 1'b1;
        default:  is_mul_s = 1'b0;
      endcase
    end else begin
      is_mul_s = 1'b0;
    end
  end

  assign is_mdu_s = is_mul_s | is_div_s | mthi_s | mtlo_s | mfhi_s | mflo_s;
  assign neg_a_s  = is_signed_s & A[WIDTH-1];
  assign neg_b_s  = is_signed_s & B[WIDTH-1];
  assign mag_a_s  = neg_a_s ? -A : A;
  assign mag_b_s  = neg_b_s ? -B : B;

  // Next-state logic; the counter reaching 1 marks the last iteration step.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mul_s) begin
          state_s = MUL;
          load_s  = 1'b1;
        end else if (is_div_s) begin
          state_s = DIV;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      MUL, DIV: begin
        step_s = 1'b1;
        if (cnt_r == CNT_W'(1)) begin
          state_s = FIX;
        end else begin
          state_s = state_r;
        end
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sign restoration; a zero divisor keeps the all-ones quotient unnegated.
  always_comb begin
    quo_s  = core_p_s[WIDTH-1:0];
    prod_s = core_p_s;
    if (sign_a_r ^ sign_b_r) begin
      prod_s = -core_p_s;
      quo_s  = div0_r ? core_p_s[WIDTH-1:0] : -core_p_s[WIDTH-1:0];
    end else begin
      prod_s = core_p_s;
    end
    if (sign_a_r) begin
      rem_s = -core_p_s[2*WIDTH-1:WIDTH];
    end else begin
      rem_s = core_p_s[2*WIDTH-1:WIDTH];
    end
    if (op_div_r) begin
      fix_hi_s = rem_s;
      fix_lo_s = quo_s;
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // MFHI/MFLO read port; HI/LO are already updated while in DONE.
  always_comb begin
    result_s = '0;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      if (mfhi_s) begin
        result_s = hi_r;
      end else if (mflo_s) begin
        result_s = lo_r;
      end else begin
        result_s = '0;
      end
    end else begin
      result_s = '0;
    end
  end

  // Control, operand-sign and architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      div0_r   <= 1'b0;
      op_div_r <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == MUL) || (state_s == DIV) || (state_s == FIX);
      done_r  <= (state_s == DONE);
      if (load_s) begin
        cnt_r    <= CNT_W'(WIDTH);
        sign_a_r <= neg_a_s;
        sign_b_r <= neg_b_s;
        div0_r   <= is_div_s && (B == '0);
        op_div_r <= is_div_s;
      end else if (step_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (state_r == FIX) begin
        hi_r <= fix_hi_s;
        lo_r <= fix_lo_s;
      end else if ((state_r == IDLE) && mthi_s) begin
        hi_r <= A;
      end else if ((state_r == IDLE) && mtlo_s) begin
        lo_r <= A;
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .step     (step_s),
    .div_mode (state_r == DIV),
    .lo_in    (is_div_s ? mag_a_s : mag_b_s),
    .d_in     (is_div_s ? mag_b_s : mag_a_s),
    .p        (core_p_s)
  );

  assign Result = result_s;
  assign HI     = hi_r;
  assign LO     = lo_r;
  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Stall  = is_mdu_s && ((state_r == MUL) || (state_r == DIV) || (state_r == FIX));

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit (WIDTH=32) against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int         W     = 32;
  localparam logic [2:0] RTYPE = 3'b111;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    ALUOp;
  logic [5:0]    ALUFunction;
  logic          Valid;
  logic [W-1:0]  A, B;
  logic [W-1:0]  Result, HI, LO;
  logic          Busy, Done, Stall;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .ALUFunction(ALUFunction), .Valid(Valid),
    .A(A), .B(B), .Result(Result), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] ref_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fn)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
      F_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: every Done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && Done) begin
      if (sb_q.size() == 0) begin
        timeout("unexpected_done_no_pending_op");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check32("done_hi", HI, e.hi);
        check32("done_lo", LO, e.lo);
        check32("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    ALUOp = op; ALUFunction = fn; A = a; B = b; Valid = 1'b1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((Busy || Done) && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) timeout("wait_idle");
  endtask

  task automatic drain();
    int g = 0;
    while ((sb_q.size() != 0 || Busy || Done) && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) timeout("drain");
  endtask

  task automatic mdu_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] r;
    wait_idle();
    r = ref_md(fn, a, b);
    e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = cyc + W + 2;
    sb_q.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    drive(RTYPE, fn, a, b);
    @(negedge clk);
    Valid = 1'b0;
    check32("busy_after_accept", {31'd0, Busy}, 32'd1);
  endtask

  task automatic directed(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] xhi, input logic [31:0] xlo);
    mdu_op(fn, a, b);
    drain();
    check32("directed_hi", HI, xhi);
    check32("directed_lo", LO, xlo);
  endtask

  task automatic mt_op(input logic [5:0] fn, input logic [31:0] a);
    wait_idle();
    drive(RTYPE, fn, a, 32'd0);
    @(negedge clk);
    Valid = 1'b0;
    if (fn == F_MTHI) m_hi = a; else m_lo = a;
    check32("mt_hi", HI, m_hi);
    check32("mt_lo", LO, m_lo);
  endtask

  task automatic rd(input logic [5:0] fn);
    drive(RTYPE, fn, 32'd0, 32'd0);
    #1;
    check32(fn == F_MFHI ? "mfhi_result" : "mflo_result", Result, fn == F_MFHI ? m_hi : m_lo);
    @(negedge clk);
    Valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0]  fn;
    logic [31:0] a, b;
    int          g;
    exp_t        e;
    logic [63:0] r;

    reset = 1'b1; Valid = 1'b1; ALUOp = RTYPE; ALUFunction = F_MFHI; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check32("reset_busy", {31'd0, Busy}, 32'd0);
    check32("reset_done", {31'd0, Done}, 32'd0);
    check32("reset_stall", {31'd0, Stall}, 32'd0);
    check32("reset_hi", HI, 32'd0);
    check32("reset_lo", LO, 32'd0);
    check32("reset_result", Result, 32'd0);
    Valid = 1'b0;
    reset = 1'b0;

    // Spec examples; the first is issued on the first edge after reset release.
    directed(F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    directed(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    directed(F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    directed(F_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    directed(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
    directed(F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);

    mt_op(F_MTHI, 32'h12345678);
    mt_op(F_MTLO, 32'hCAFEF00D);
    rd(F_MFHI);
    rd(F_MFLO);
    A = 32'h5; Valid = 1'b0; ALUFunction = F_MFHI; #1;
    check32("result_no_valid", Result, 32'd0);

    // Non R-type class and unknown funct codes must not touch state.
    drive(3'b000, F_MTHI, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    drive(3'b010, F_MULT, 32'd3, 32'd3);
    #1 check32("nonrtype_result", Result, 32'd0);
    @(negedge clk);
    drive(RTYPE, 6'b100000, 32'd9, 32'd9);
    @(negedge clk);
    Valid = 1'b0;
    check32("ignored_busy", {31'd0, Busy}, 32'd0);
    check32("ignored_hi", HI, m_hi);
    check32("ignored_lo", LO, m_lo);

    // Read held under Stall until the product lands, then bypassed in DONE.
    mdu_op(F_MULT, 32'h00012345, 32'hFFFF0001);
    @(negedge clk);
    drive(RTYPE, F_MFLO, 32'd0, 32'd0);
    g = 0;
    while (!Done && g < 60) begin
      #1;
      check32("stall_while_busy", {31'd0, Stall}, 32'd1);
      check32("result_while_busy", Result, 32'd0);
      @(negedge clk);
      g++;
    end
    if (g >= 60) timeout("stall_done");
    #1;
    check32("stall_in_done", {31'd0, Stall}, 32'd0);
    check32("bypass_result", Result, m_lo);
    Valid = 1'b0;

    // An op offered during DONE is taken only on the following IDLE edge.
    mdu_op(F_MULTU, 32'd1000, 32'd1000);
    g = 0;
    while (!Done && g < 60) begin @(negedge clk); g++; end
    if (g >= 60) timeout("b2b_done");
    r = ref_md(F_DIVU, 32'd1000001, 32'd7);
    e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = cyc + W + 3;
    sb_q.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    drive(RTYPE, F_DIVU, 32'd1000001, 32'd7);
    #1 check32("stall_new_op_in_done", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    check32("not_accepted_in_done", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    Valid = 1'b0;
    check32("accepted_in_idle", {31'd0, Busy}, 32'd1);
    drain();

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       fn = F_MULT;
        1:       fn = F_MULTU;
        2:       fn = F_DIV;
        default: fn = F_DIVU;
      endcase
      a = pick_val();
      b = pick_val();
      mdu_op(fn, a, b);
      if (i % 5 == 4) begin
        drain();
        rd(F_MFHI);
        rd(F_MFLO);
      end
    end
    drain();

    // Reset in the middle of a multiply discards it completely.
    mdu_op(F_MULT, 32'h00ABCDEF, 32'h00001234);
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check32("midreset_busy", {31'd0, Busy}, 32'd0);
    check32("midreset_done", {31'd0, Done}, 32'd0);
    check32("midreset_hi", HI, 32'd0);
    check32("midreset_lo", LO, 32'd0);
    check32("midreset_stall", {31'd0, Stall}, 32'd0);
    sb_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    directed(F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
